// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller.
// A single 4-bit carry-select slice is reused once per clock, LSB nibble
// first, to build a WIDTH-bit sum. The requester sees a start/ready/done
// handshake. The result, carry-out and signed overflow are held until the
// next operation completes.

// 4-bit carry-select slice: two precomputed ripple chains, picked by cin.
module nibble_csel_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c0_chain;
    logic [4:0] c1_chain;
    logic [3:0] s0;
    logic [3:0] s1;

    assign c0_chain[0] = 1'b0;
    assign c1_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_bit
            assign s0[gi]         = a[gi] ^ b[gi] ^ c0_chain[gi];
            assign s1[gi]         = a[gi] ^ b[gi] ^ c1_chain[gi];
            assign c0_chain[gi+1] = (a[gi] & b[gi]) | (c0_chain[gi] & (a[gi] ^ b[gi]));
            assign c1_chain[gi+1] = (a[gi] & b[gi]) | (c1_chain[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    // Late-arriving carry only steers the final mux.
    always_comb begin
        sum  = cin ? s1 : s0;
        cout = cin ? c1_chain[4] : c0_chain[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] aop_reg;
    logic [WIDTH-1:0] bop_reg;
    logic             carry_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             msba_reg;
    logic             msbb_reg;
    logic [WIDTH-1:0] partial_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] partial_next;

    // Present the current nibble of each captured operand to the slice.
    always_comb begin
        slice_a = aop_reg[4*idx_reg +: 4];
        slice_b = bop_reg[4*idx_reg +: 4];
    end

    nibble_csel_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Partial sum with this cycle's nibble merged in; on the last nibble
    // this is the full result, so it can be loaded straight into Sum.
    always_comb begin
        partial_next = partial_reg;
        partial_next[4*idx_reg +: 4] = slice_sum;
    end

    // Controller: capture on start, step one nibble per clock, then pulse done.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            aop_reg     <= '0;
            bop_reg     <= '0;
            carry_reg   <= 1'b0;
            idx_reg     <= '0;
            msba_reg    <= 1'b0;
            msbb_reg    <= 1'b0;
            partial_reg <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B here, seed carry with 1.
                        aop_reg   <= A;
                        bop_reg   <= sub ? ~B : B;
                        carry_reg <= sub;
                        idx_reg   <= '0;
                        msba_reg  <= A[WIDTH-1];
                        msbb_reg  <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    partial_reg <= partial_next;
                    carry_reg   <= slice_cout;
                    idx_reg     <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_DONE;
                        sum_reg   <= partial_next;
                        cout_reg  <= slice_cout;
                        ovf_reg   <= (msba_reg == msbb_reg) &&
                                     (partial_next[WIDTH-1] != msba_reg);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode directly from state; results come from holding regs.
    always_comb begin
        ready = (state_reg == ST_IDLE);
        busy  = (state_reg != ST_IDLE);
        done  = (state_reg == ST_DONE);
        Sum   = sum_reg;
        cout  = cout_reg;
        ovf   = ovf_reg;
    end
endmodule
